// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register indices, array geometry
// and the destination-select encoding used by decode and write-back.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_sel_e;

  // jal outranks regdst: a link write always lands in $31.
  function automatic dst_sel_e dst_code(
    input logic regdst,
    input logic jal
  );
    if (jal)
      return DST_RA;
    else if (regdst)
      return DST_RD;
    else
      return DST_RT;
  endfunction

endpackage

// File: rtl/wb_dest_sel.sv
// Write-back destination resolution: rt, rd or $31 (jal).
// Ports: rt_addr, rd_addr, regdst, jal in; wr_dest out.
module wb_dest_sel
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  regdst,
  input  logic                  jal,
  output logic [REG_ADDR_W-1:0] wr_dest
);

  dst_sel_e sel;

  assign sel = dst_code(regdst, jal);

  always_comb begin
    wr_dest = rt_addr;
    unique case (1'b1)
      (sel == DST_RA): wr_dest = REG_RA;
      (sel == DST_RD): wr_dest = rd_addr;
      (sel == DST_RT): wr_dest = rt_addr;
      default:         wr_dest = rt_addr;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 MIPS register file with write-back destination select,
// two combinational read ports and a saturating committed-write
// counter. Ports: clk, rst_n, rs/rt/rd_addr, regdst, jal,
// regwrite, wb_data in; rs_data, rt_data, wr_dest, wr_count out.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through reads.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  regdst,
  input  logic                  jal,
  input  logic                  regwrite,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [REG_ADDR_W-1:0] wr_dest,
  output logic [CNT_W-1:0]      wr_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;

  wb_dest_sel u_dest (
    .rt_addr (rt_addr),
    .rd_addr (rd_addr),
    .regdst  (regdst),
    .jal     (jal),
    .wr_dest (wr_dest)
  );

  assign wr_commit = regwrite && (wr_dest != REG_ZERO);

  // Only a committed write touches the array, so X on wb_data
  // with regwrite low cannot leak into state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_commit) begin
      regs[wr_dest] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_count <= '0;
    else if (wr_commit && (wr_count != '1))
      wr_count <= wr_count + CNT_W'(1);
  end

`ifdef WB_REGFILE_BYPASS_EN
  // wr_commit already excludes $0, so $0 never forwards.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (wr_commit && (rs_addr == wr_dest))
      rs_data = wb_data;
    if (wr_commit && (rt_addr == wr_dest))
      rt_data = wb_data;
    if (rs_addr == REG_ZERO)
      rs_data = '0;
    if (rt_addr == REG_ZERO)
      rt_data = '0;
  end
`else
  assign rs_data = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
  assign rt_data = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a queue scoreboard.
// Counter is built 4 bits wide so saturation is reachable.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs_addr, rt_addr, rd_addr;
  logic          regdst, jal, regwrite;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] rs_data, rt_data;
  logic [4:0]    wr_dest;
  logic [CW-1:0] wr_count;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mregs [32];
  int          mcnt;

  wb_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_addr  (rd_addr),
    .regdst   (regdst),
    .jal      (jal),
    .regwrite (regwrite),
    .wb_data  (wb_data),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wr_dest  (wr_dest),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic drive(
    input logic [4:0]  rs, rt, rd,
    input logic        rdst, j, we,
    input logic [31:0] d
  );
    rs_addr  = rs;
    rt_addr  = rt;
    rd_addr  = rd;
    regdst   = rdst;
    jal      = j;
    regwrite = we;
    wb_data  = d;
  endtask

  function automatic logic [4:0] mdest();
    if (jal) return 5'd31;
    return regdst ? rd_addr : rt_addr;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = 0;
  endtask

  // Advance one edge, update the reference model, settle 1ns.
  task automatic tick();
    logic [4:0] d;
    @(posedge clk);
    d = mdest();
    if (rst_n && regwrite && d != 5'd0) begin
      mregs[d] = wb_data;
      if (mcnt < 15) mcnt++;
    end
    #1;
  endtask

  initial begin
    mclear();
    rst_n = 1'b0;
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_rs", 32'h0);
    chk(rs_data);
    expect_v("rst_cnt", 32'h0);
    chk(32'(wr_count));
    rst_n = 1'b1;

    // Write $5 then assert reset mid-cycle with a pending write.
    drive(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    drive(5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    expect_v("pre_rst_5", 32'hDEADBEEF);
    chk(rs_data);
    drive(5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 32'h77);
    #2;
    rst_n = 1'b0;
    mclear();
    #1;
    expect_v("async_rst_5", 32'h0);
    chk(rs_data);
    expect_v("async_rst_cnt", 32'h0);
    chk(32'(wr_count));
    tick();
    rst_n = 1'b1;
    drive(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("lost_write_6", 32'h0);
    chk(rs_data);

    // R-type write to $8.
    drive(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h12345678);
    tick();
    drive(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("rtype_8", 32'h12345678);
    chk(rs_data);
    expect_v("rtype_cnt", 32'd1);
    chk(32'(wr_count));

    // JAL override: rd=4 must be ignored.
    drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0000AAAA);
    tick();
    drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1, 32'h00400008);
    #1;
    expect_v("jal_dest", 32'd31);
    chk(32'(wr_dest));
    tick();
    drive(5'd31, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("jal_ra", 32'h00400008);
    chk(rs_data);
    expect_v("jal_4", 32'h0000AAAA);
    chk(rt_data);
    expect_v("jal_cnt", 32'd3);
    chk(32'(wr_count));

    // jal without regwrite: no write, no count.
    drive(5'd31, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h55);
    #1;
    expect_v("jal_nowe_dest", 32'd31);
    chk(32'(wr_dest));
    tick();
    expect_v("jal_nowe_ra", mregs[31]);
    chk(rs_data);
    expect_v("jal_nowe_cnt", 32'(mcnt));
    chk(32'(wr_count));

    // $0 protection, including a same-cycle read of $0.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    #1;
    expect_v("zero_rs_during", 32'h0);
    chk(rs_data);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("zero_rt", 32'h0);
    chk(rt_data);
    expect_v("zero_cnt", 32'd3);
    chk(32'(wr_count));

    // Read during write on $9.
    drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h1);
    tick();
    drive(5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 32'h2);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    expect_v("rdw_rs", 32'h2);
    expect_v("rdw_rt", 32'h2);
`else
    expect_v("rdw_rs", 32'h1);
    expect_v("rdw_rt", 32'h1);
`endif
    chk(rs_data);
    chk(rt_data);
    tick();
    drive(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("rdw_after", 32'h2);
    chk(rs_data);

    // X on wb_data with regwrite low must not disturb state.
    drive(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 'x);
    tick();
    expect_v("x_hold_9", 32'h2);
    chk(rs_data);
    expect_v("x_hold_cnt", 32'd5);
    chk(32'(wr_count));

    // 20 committed writes saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(5'd0, 5'd0, 5'((i % 30) + 1), 1'b1, 1'b0, 1'b1,
            32'hC000_0000 + 32'(i));
      tick();
    end
    drive(5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    expect_v("sat_cnt", 32'd15);
    chk(32'(wr_count));
    expect_v("sat_last_reg", 32'hC000_0013);
    chk(rs_data);
    repeat (3) tick();
    expect_v("sat_idle_cnt", 32'd15);
    chk(32'(wr_count));
    expect_v("model_cnt", 32'(mcnt));
    chk(32'(wr_count));

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_left observed=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
